// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like bus port between instruction fetch and data access.
// One outstanding transaction; results are held until the pipeline advances.
module mem_port_arbiter #(
   parameter bit          DATA_FIRST       = 1'b1,
   parameter int unsigned RESET_STATE_IDLE = 1
) (
   input  logic        clk,
   input  logic        rst,
   // Instruction fetch side
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic [31:0] inst_rdata,
   output logic        inst_stall,
   // Data access side
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_stall,
   // Pipeline control
   input  logic        pipe_stall,
   input  logic        flush,
   // Shared bus
   output logic        bus_req,
   output logic        bus_wr,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_addr_ok,
   input  logic        bus_data_ok,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [2:0] {StIdle, StDAddr, StDData, StIAddr, StIData} state_t;

   if (RESET_STATE_IDLE != 1) begin : gen_reset_state_check
      $error("mem_port_arbiter always resets to IDLE; RESET_STATE_IDLE must be 1");
   end

   state_t      stateQ;
   logic        instDoneQ;
   logic        dataDoneQ;
   logic        discardQ;
   logic [31:0] instRdataQ;
   logic [31:0] dataRdataQ;
   logic        busReqQ;
   logic        busWrQ;
   logic [3:0]  busWstrbQ;
   logic [31:0] busAddrQ;
   logic [31:0] busWdataQ;

   logic        advance;
   logic        pickData;

   assign inst_stall = inst_req & ~instDoneQ;
   assign data_stall = data_req & ~dataDoneQ;

   // Pipeline moves forward only when nobody (including us) is stalling it.
   assign advance  = ~pipe_stall & ~inst_stall & ~data_stall;
   assign pickData = data_stall & (~inst_stall | DATA_FIRST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateQ     <= StIdle;
         instDoneQ  <= 1'b0;
         dataDoneQ  <= 1'b0;
         discardQ   <= 1'b0;
         instRdataQ <= 32'h0;
         dataRdataQ <= 32'h0;
         busReqQ    <= 1'b0;
         busWrQ     <= 1'b0;
         busWstrbQ  <= 4'h0;
         busAddrQ   <= 32'h0;
         busWdataQ  <= 32'h0;
      end else begin
         if (advance) begin
            instDoneQ <= 1'b0;
            dataDoneQ <= 1'b0;
         end
         if (flush) begin
            instDoneQ <= 1'b0;
         end

         case (stateQ)
            StIdle: begin
               if (pickData) begin
                  busReqQ   <= 1'b1;
                  busWrQ    <= data_wr;
                  busWstrbQ <= data_wr ? data_wstrb : 4'h0;
                  busAddrQ  <= data_addr;
                  busWdataQ <= data_wdata;
                  stateQ    <= StDAddr;
               end else if (inst_stall) begin
                  busReqQ   <= 1'b1;
                  busWrQ    <= 1'b0;
                  busWstrbQ <= 4'h0;
                  busAddrQ  <= inst_addr;
                  busWdataQ <= 32'h0;
                  // A fetch launched on the flush edge carries a stale PC.
                  discardQ  <= flush;
                  stateQ    <= StIAddr;
               end
            end

            StDAddr: begin
               if (bus_addr_ok) begin
                  busReqQ <= 1'b0;
                  stateQ  <= StDData;
               end
            end

            StDData: begin
               if (bus_data_ok) begin
                  if (!busWrQ) begin
                     dataRdataQ <= bus_rdata;
                  end
                  dataDoneQ <= 1'b1;
                  stateQ    <= StIdle;
               end
            end

            StIAddr: begin
               if (flush) begin
                  discardQ <= 1'b1;
               end
               if (bus_addr_ok) begin
                  busReqQ <= 1'b0;
                  stateQ  <= StIData;
               end
            end

            StIData: begin
               if (bus_data_ok) begin
                  // Flush arriving with the data kills the result just like an earlier flush.
                  if (!discardQ && !flush) begin
                     instRdataQ <= bus_rdata;
                     instDoneQ  <= 1'b1;
                  end
                  discardQ <= 1'b0;
                  stateQ   <= StIdle;
               end else if (flush) begin
                  discardQ <= 1'b1;
               end
            end

            default: begin
               busReqQ <= 1'b0;
               stateQ  <= StIdle;
            end
         endcase
      end
   end

   assign inst_rdata = instRdataQ;
   assign data_rdata = dataRdataQ;
   assign bus_req    = busReqQ;
   assign bus_wr     = busWrQ;
   assign bus_wstrb  = busWstrbQ;
   assign bus_addr   = busAddrQ;
   assign bus_wdata  = busWdataQ;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected bus
// transactions and results; a monitor pops them as the DUT presents them.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic [31:0] inst_rdata;
   logic        inst_stall;
   logic        data_req;
   logic        data_wr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        data_stall;
   logic        pipe_stall;
   logic        flush;
   logic        bus_req;
   logic        bus_wr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_addr_ok;
   logic        bus_data_ok;
   logic [31:0] bus_rdata;

   mem_port_arbiter #(
      .DATA_FIRST       (1'b1),
      .RESET_STATE_IDLE (1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .inst_req    (inst_req),
      .inst_addr   (inst_addr),
      .inst_rdata  (inst_rdata),
      .inst_stall  (inst_stall),
      .data_req    (data_req),
      .data_wr     (data_wr),
      .data_wstrb  (data_wstrb),
      .data_addr   (data_addr),
      .data_wdata  (data_wdata),
      .data_rdata  (data_rdata),
      .data_stall  (data_stall),
      .pipe_stall  (pipe_stall),
      .flush       (flush),
      .bus_req     (bus_req),
      .bus_wr      (bus_wr),
      .bus_wstrb   (bus_wstrb),
      .bus_addr    (bus_addr),
      .bus_wdata   (bus_wdata),
      .bus_addr_ok (bus_addr_ok),
      .bus_data_ok (bus_data_ok),
      .bus_rdata   (bus_rdata)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        wr;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
   } busTxn_t;

   busTxn_t     busQ[$];
   logic [31:0] instQ[$];
   logic [31:0] dataQ[$];

   int          errors = 0;
   int          checks = 0;
   int          addrDelay = 0;
   int          dataDelay = 0;
   logic [31:0] slaveRdata = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic expBus(input logic wr, input logic [3:0] s, input logic [31:0] a,
                         input logic [31:0] d);
      busTxn_t t;
      t.wr    = wr;
      t.wstrb = s;
      t.addr  = a;
      t.wdata = d;
      busQ.push_back(t);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Returns at the negedge where the chosen stall is low; n = high cycles seen.
   task automatic waitLow(input bit isData, output int n);
      n = 0;
      @(negedge clk);
      while ((isData ? data_stall : inst_stall) && n < 60) begin
         n++;
         @(negedge clk);
      end
      if (n >= 60) begin
         checks++;
         errors++;
         $display("FAIL stall_timeout: got stall still high after %0d cycles, expected low", n);
      end
   endtask

   // Returns at the negedge of the address handshake (0) or the data return (1).
   task automatic waitBus(input bit dataPhase);
      int n = 0;
      @(negedge clk);
      while (!(dataPhase ? bus_data_ok : (bus_req && bus_addr_ok)) && n < 60) begin
         n++;
         @(negedge clk);
      end
      if (n >= 60) begin
         checks++;
         errors++;
         $display("FAIL bus_timeout: got no handshake in %0d cycles, expected one", n);
      end
   endtask

   // Bus slave: addr_ok after addrDelay cycles of bus_req, data_ok dataDelay cycles later.
   initial begin : slave
      int waitCnt;
      bit accepted;
      waitCnt     = 0;
      accepted    = 1'b0;
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      bus_rdata   = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         bus_addr_ok = 1'b0;
         bus_data_ok = 1'b0;
         if (rst) begin
            waitCnt  = 0;
            accepted = 1'b0;
         end else if (accepted) begin
            if (waitCnt == dataDelay) begin
               bus_data_ok = 1'b1;
               bus_rdata   = slaveRdata;
               accepted    = 1'b0;
               waitCnt     = 0;
            end else begin
               waitCnt++;
            end
         end else if (bus_req) begin
            if (waitCnt == addrDelay) begin
               bus_addr_ok = 1'b1;
               accepted    = 1'b1;
               waitCnt     = 0;
            end else begin
               waitCnt++;
            end
         end
      end
   end

   initial begin : monitor
      bit      prevInst;
      bit      prevData;
      busTxn_t e;
      logic [31:0] v;
      prevInst = 1'b0;
      prevData = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (bus_req && bus_addr_ok) begin
               if (busQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL bus_unexpected: got addr 0x%08h, expected no transaction", bus_addr);
               end else begin
                  e = busQ.pop_front();
                  chk("bus_addr", bus_addr, e.addr);
                  chk("bus_wr", 32'(bus_wr), 32'(e.wr));
                  chk("bus_wstrb", 32'(bus_wstrb), 32'(e.wstrb));
                  if (e.wr) chk("bus_wdata", bus_wdata, e.wdata);
               end
            end
            if (inst_req && !inst_stall && prevInst) begin
               if (instQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL inst_unexpected: got rdata 0x%08h, expected no completion", inst_rdata);
               end else begin
                  v = instQ.pop_front();
                  chk("inst_rdata", inst_rdata, v);
               end
            end
            if (data_req && !data_stall && prevData) begin
               if (dataQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL data_unexpected: got rdata 0x%08h, expected no completion", data_rdata);
               end else begin
                  v = dataQ.pop_front();
                  chk("data_rdata", data_rdata, v);
               end
            end
         end
         prevInst = inst_stall;
         prevData = data_stall;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no finish by time limit, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int n;
      int dLow;
      int iLow;
      int high;
      rst        = 1'b1;
      inst_req   = 1'b0;
      inst_addr  = 32'h0;
      data_req   = 1'b0;
      data_wr    = 1'b0;
      data_wstrb = 4'h0;
      data_addr  = 32'h0;
      data_wdata = 32'h0;
      pipe_stall = 1'b0;
      flush      = 1'b0;

      // Reset state
      repeat (2) cyc();
      chk("rst_bus_req", 32'(bus_req), 32'd0);
      chk("rst_bus_wr", 32'(bus_wr), 32'd0);
      chk("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
      chk("rst_bus_addr", bus_addr, 32'h0);
      chk("rst_bus_wdata", bus_wdata, 32'h0);
      chk("rst_inst_rdata", inst_rdata, 32'h0);
      chk("rst_data_rdata", data_rdata, 32'h0);
      inst_req = 1'b1;
      #1;
      chk("rst_inst_stall_follows_req", 32'(inst_stall), 32'd1);
      chk("rst_data_stall", 32'(data_stall), 32'd0);
      inst_req = 1'b0;
      cyc();
      rst = 1'b0;
      cyc();

      // Single fetch, minimum latency
      slaveRdata = 32'h24020001;
      expBus(1'b0, 4'h0, 32'hbfc00000, 32'h0);
      instQ.push_back(32'h24020001);
      inst_addr = 32'hbfc00000;
      inst_req  = 1'b1;
      waitLow(1'b0, n);
      chk("fetch_stall_cycles", 32'(n), 32'd3);
      #1 inst_req = 1'b0;
      cyc();

      // Store and fetch together: store first, fetch issued via IDLE afterwards
      slaveRdata = 32'h3c1d8000;
      expBus(1'b1, 4'hf, 32'h80001000, 32'h12345678);
      expBus(1'b0, 4'h0, 32'hbfc00000, 32'h0);
      dataQ.push_back(32'h0);
      instQ.push_back(32'h3c1d8000);
      data_wr    = 1'b1;
      data_wstrb = 4'hf;
      data_addr  = 32'h80001000;
      data_wdata = 32'h12345678;
      data_req   = 1'b1;
      inst_addr  = 32'hbfc00000;
      inst_req   = 1'b1;
      dLow = -1;
      iLow = -1;
      for (int i = 0; i < 60 && iLow < 0; i++) begin
         @(negedge clk);
         if (dLow < 0 && !data_stall) dLow = i;
         if (!inst_stall) iLow = i;
      end
      chk("store_done_cycle", 32'(dLow), 32'd3);
      chk("fetch_after_store_cycle", 32'(iLow), 32'd6);
      #1;
      data_req = 1'b0;
      inst_req = 1'b0;
      data_wr  = 1'b0;
      cyc();

      // Result held under pipe_stall, cleared by the advance
      pipe_stall = 1'b1;
      slaveRdata = 32'h8fa40000;
      expBus(1'b0, 4'h0, 32'hbfc00004, 32'h0);
      instQ.push_back(32'h8fa40000);
      inst_addr = 32'hbfc00004;
      inst_req  = 1'b1;
      waitLow(1'b0, n);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("hold_rdata", inst_rdata, 32'h8fa40000);
         chk("hold_stall", 32'(inst_stall), 32'd0);
         chk("hold_no_bus_req", 32'(bus_req), 32'd0);
      end
      #1 pipe_stall = 1'b0;
      @(negedge clk);
      chk("advance_clears_done", 32'(inst_stall), 32'd1);
      #1 inst_req = 1'b0;
      cyc();

      // Load: strobes forced to zero on the bus, word captured
      slaveRdata = 32'hcafef00d;
      expBus(1'b0, 4'h0, 32'h80002000, 32'h0);
      dataQ.push_back(32'hcafef00d);
      data_wr    = 1'b0;
      data_wstrb = 4'h3;
      data_addr  = 32'h80002000;
      data_wdata = 32'h0;
      data_req   = 1'b1;
      waitLow(1'b1, n);
      chk("load_stall_cycles", 32'(n), 32'd3);
      #1 data_req = 1'b0;
      cyc();

      // Flush during I_DATA: first fetch discarded, new PC fetched
      dataDelay  = 2;
      slaveRdata = 32'hdeadbeef;
      expBus(1'b0, 4'h0, 32'h80000010, 32'h0);
      expBus(1'b0, 4'h0, 32'hbfc00380, 32'h0);
      instQ.push_back(32'h3c080000);
      inst_addr = 32'h80000010;
      inst_req  = 1'b1;
      waitBus(1'b0);
      @(negedge clk);
      #1;
      flush     = 1'b1;
      inst_addr = 32'hbfc00380;
      cyc();
      flush = 1'b0;
      waitBus(1'b1);
      #1 slaveRdata = 32'h3c080000;
      @(negedge clk);
      chk("flush_rdata_kept", inst_rdata, 32'h8fa40000);
      chk("flush_done_clear", 32'(inst_stall), 32'd1);
      waitLow(1'b0, n);
      #1 inst_req = 1'b0;
      cyc();

      // Flush in the same cycle as data_ok
      dataDelay  = 0;
      slaveRdata = 32'h11111111;
      expBus(1'b0, 4'h0, 32'h80000020, 32'h0);
      expBus(1'b0, 4'h0, 32'hbfc00380, 32'h0);
      instQ.push_back(32'h22222222);
      inst_addr = 32'h80000020;
      inst_req  = 1'b1;
      waitBus(1'b0);
      @(posedge clk);
      #1;
      flush     = 1'b1;
      inst_addr = 32'hbfc00380;
      @(negedge clk);
      #1 slaveRdata = 32'h22222222;
      cyc();
      flush = 1'b0;
      @(negedge clk);
      chk("flush_ok_rdata_kept", inst_rdata, 32'h3c080000);
      chk("flush_ok_done_clear", 32'(inst_stall), 32'd1);
      waitLow(1'b0, n);
      #1 inst_req = 1'b0;
      cyc();

      // Slow slave: bus fields stable while bus_req waits for addr_ok
      addrDelay = 5;
      expBus(1'b1, 4'h5, 32'h80003000, 32'ha5a5a5a5);
      dataQ.push_back(32'hcafef00d);
      data_wr    = 1'b1;
      data_wstrb = 4'h5;
      data_addr  = 32'h80003000;
      data_wdata = 32'ha5a5a5a5;
      data_req   = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus_req && n < 10) begin
         n++;
         @(negedge clk);
      end
      high = 0;
      while (bus_req && high < 20) begin
         chk("slow_addr_stable", bus_addr, 32'h80003000);
         chk("slow_wdata_stable", bus_wdata, 32'ha5a5a5a5);
         chk("slow_wstrb_stable", 32'(bus_wstrb), 32'h5);
         high++;
         @(negedge clk);
      end
      chk("slow_req_cycles", 32'(high), 32'd6);
      waitLow(1'b1, n);
      #1;
      data_req  = 1'b0;
      data_wr   = 1'b0;
      addrDelay = 0;
      cyc();

      // Asynchronous reset while a load sits in D_DATA
      dataDelay = 3;
      expBus(1'b0, 4'h0, 32'h80004000, 32'h0);
      data_addr = 32'h80004000;
      data_req  = 1'b1;
      inst_addr = 32'hbfc00000;
      inst_req  = 1'b1;
      waitBus(1'b0);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("arst_bus_req", 32'(bus_req), 32'd0);
      chk("arst_data_rdata", data_rdata, 32'h0);
      chk("arst_inst_rdata", inst_rdata, 32'h0);
      chk("arst_data_stall", 32'(data_stall), 32'd1);
      chk("arst_inst_stall", 32'(inst_stall), 32'd1);
      data_req = 1'b0;
      inst_req = 1'b0;
      #1;
      chk("arst_data_stall_drop", 32'(data_stall), 32'd0);
      chk("arst_inst_stall_drop", 32'(inst_stall), 32'd0);
      cyc();
      cyc();
      rst       = 1'b0;
      dataDelay = 0;
      cyc();

      // Recovery after reset
      slaveRdata = 32'h24020001;
      expBus(1'b0, 4'h0, 32'hbfc00000, 32'h0);
      instQ.push_back(32'h24020001);
      inst_req = 1'b1;
      waitLow(1'b0, n);
      chk("post_reset_fetch_cycles", 32'(n), 32'd3);
      #1 inst_req = 1'b0;
      repeat (3) cyc();

      chk("bus_queue_drained", 32'(busQ.size()), 32'd0);
      chk("inst_queue_drained", 32'(instQ.size()), 32'd0);
      chk("data_queue_drained", 32'(dataQ.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
